branch_sequencer: RTL and testbench

- Multicycle instruction sequencer that owns the architectural PC and drives the branch unit's 3-bit BRANCH code.
- Runs each instruction through fetch, decode, execute-or-branch and PC update.
- Handshakes with instruction memory and the ALU/memory execute path.
- Latches the branch unit's NPC result, checks alignment, and halts on faults.

---
 rtl/branch_sequencer_if.sv | 33 +++
 rtl/branch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_branch_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if
//   Bundles the sequencer's handshakes with instruction memory, the decoder,
//   the execute path and the branch unit.
//   master: the sequencer (drives requests, strobes, branch code, pc + 4)
//   slave : the surrounding datapath (drives acks, decode flags, NPC)
//
//   imem_req / imem_ack / ir_load     instruction fetch handshake
//   is_branch / br_type / is_halt     decode results for the current IR
//   exec_start / exec_done            execute handshake
//   branch_code / npc_in / pc_plus_4  branch unit exchange
interface branch_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_load;
    logic        is_branch;
    logic [1:0]  br_type;
    logic        is_halt;
    logic        exec_start;
    logic        exec_done;
    logic [2:0]  branch_code;
    logic [31:0] npc_in;
    logic [31:0] pc_plus_4;

    modport master (
        output imem_req, ir_load, exec_start, branch_code, pc_plus_4,
        input  imem_ack, is_branch, br_type, is_halt, exec_done, npc_in
    );

    modport slave (
        input  imem_req, ir_load, exec_start, branch_code, pc_plus_4,
        output imem_ack, is_branch, br_type, is_halt, exec_done, npc_in
    );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Multicycle instruction sequencer. Owns the architectural PC, walks each
//   instruction through fetch / decode / execute-or-branch / PC update,
//   drives the branch unit's 3-bit code and halts on misaligned NPC or
//   execute timeout (sticky fault, cleared only by reset).
//
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     bus          branch_sequencer_if.master handshake bundle
//     pc           architectural PC          pc_we    PC update strobe
//     resume       leave halt (no fault)     halted   in halt state
//     fault        sticky fault flag         retired  retired count (wraps)
//     branch_cnt   branches executed         taken_cnt branches taken
//
//   Optional feature macro: BRANCH_STATS_EN enables the saturating
//   branch_cnt / taken_cnt counters; without it both read as zero.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FETCH  | request instruction, load IR on imem_ack
//   S_DECODE | one cycle: pick halt / branch / execute
//   S_EXEC   | start execute, wait for exec_done or timeout
//   S_BRANCH | one cycle: present branch code, latch NPC, check alignment
//   S_UPDATE | one cycle: commit NPC to PC, count retirement
//   S_HALT   | stopped; resume only if no fault
module branch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned EXEC_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_sequencer_if.master        bus,
    output logic [31:0]               pc,
    output logic                      pc_we,
    input  logic                      resume,
    output logic                      halted,
    output logic                      fault,
    output logic [31:0]               retired,
    output logic [15:0]               branch_cnt,
    output logic [15:0]               taken_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_BRANCH = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Down-counter loaded on S_EXEC entry; reaching zero marks the last
    // allowed cycle of the execute wait.
    localparam logic [7:0] TMR_LOAD = 8'(EXEC_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] npc;
    logic [7:0]  exec_tmr;
    logic [31:0] pc_inc;
    logic        npc_misaligned;
    logic        branch_commit;

    assign pc_inc         = pc + 32'd4;
    assign bus.pc_plus_4  = pc_inc;
    assign npc_misaligned = (bus.npc_in[1:0] != 2'b00);
    assign branch_commit  = (state == S_BRANCH) && !npc_misaligned;

    always_comb begin
        state_nxt       = state;
        bus.imem_req    = 1'b0;
        bus.ir_load     = 1'b0;
        bus.exec_start  = 1'b0;
        bus.branch_code = 3'b000;
        pc_we           = 1'b0;
        halted          = 1'b0;
        case (state)
            S_FETCH: begin
                // Gated by rst_n so the fetch strobes drop the moment reset
                // asserts, without waiting for a clock.
                bus.imem_req = rst_n;
                if (bus.imem_ack) begin
                    bus.ir_load = rst_n;
                    state_nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.is_halt)
                    state_nxt = S_HALT;
                else if (bus.is_branch)
                    state_nxt = S_BRANCH;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // The timer still holds its load value only on the first cycle.
                bus.exec_start = (exec_tmr == TMR_LOAD);
                if (bus.exec_done)
                    state_nxt = S_UPDATE;
                else if (exec_tmr == 8'd0)
                    state_nxt = S_HALT;
            end
            S_BRANCH: begin
                bus.branch_code = {1'b0, bus.br_type} + 3'd1;
                state_nxt       = npc_misaligned ? S_HALT : S_UPDATE;
            end
            S_UPDATE: begin
                pc_we     = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume && !fault)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            npc      <= 32'd0;
            retired  <= 32'd0;
            fault    <= 1'b0;
            exec_tmr <= 8'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_DECODE: exec_tmr <= TMR_LOAD;
                S_EXEC: begin
                    if (bus.exec_done)
                        npc <= pc_inc;
                    else if (exec_tmr == 8'd0)
                        fault <= 1'b1;
                    else
                        exec_tmr <= exec_tmr - 8'd1;
                end
                S_BRANCH: begin
                    if (npc_misaligned)
                        fault <= 1'b1;
                    else
                        npc <= bus.npc_in;
                end
                S_UPDATE: begin
                    pc      <= npc;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] taken_cnt_q;

    // A branch whose target equals pc + 4 is counted as not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= 16'd0;
            taken_cnt_q  <= 16'd0;
        end else if (branch_commit) begin
            if (branch_cnt_q != 16'hFFFF)
                branch_cnt_q <= branch_cnt_q + 16'd1;
            if ((bus.npc_in != pc_inc) && (taken_cnt_q != 16'hFFFF))
                taken_cnt_q <= taken_cnt_q + 16'd1;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = branch_commit;
    assign branch_cnt   = 16'd0;
    assign taken_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer
//   Directed bench for branch_sequencer with RESET_PC = 0x100 and
//   EXEC_TIMEOUT = 4. Inputs change and outputs are sampled just after the
//   falling edge, away from the rising clock edge.
module tb_branch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_we;
    logic        resume;
    logic        halted;
    logic        fault;
    logic [31:0] retired;
    logic [15:0] branch_cnt;
    logic [15:0] taken_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    branch_sequencer_if bus ();

    branch_sequencer #(
        .RESET_PC     (32'h0000_0100),
        .EXEC_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .pc         (pc),
        .pc_we      (pc_we),
        .resume     (resume),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired),
        .branch_cnt (branch_cnt),
        .taken_cnt  (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic [15:0] b_exp, input logic [15:0] t_exp);
`ifdef BRANCH_STATS_EN
        chk({tag, "_branch_cnt"}, {16'd0, branch_cnt}, {16'd0, b_exp});
        chk({tag, "_taken_cnt"},  {16'd0, taken_cnt},  {16'd0, t_exp});
`else
        chk({tag, "_branch_cnt"}, {16'd0, branch_cnt}, 32'd0 & {16'd0, b_exp});
        chk({tag, "_taken_cnt"},  {16'd0, taken_cnt},  32'd0 & {16'd0, t_exp});
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        resume        = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.is_branch = 1'b0;
        bus.br_type   = 2'b00;
        bus.is_halt   = 1'b0;
        bus.exec_done = 1'b0;
        bus.npc_in    = 32'd0;

        // Reset values
        @(negedge clk); #1;
        chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_retired", retired, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_branch_code", {29'd0, bus.branch_code}, 32'd0);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
        chk_stats("rst", 16'd0, 16'd0);

        // Fetch with two wait cycles
        rst_n = 1'b1; #1;
        chk("f1_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("f1_ir_load", {31'd0, bus.ir_load}, 32'd0);
        @(negedge clk); #1;
        chk("f2_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("f2_ir_load", {31'd0, bus.ir_load}, 32'd0);
        @(negedge clk); bus.imem_ack = 1'b1; #1;
        chk("f3_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("f3_ir_load", {31'd0, bus.ir_load}, 32'd1);
        chk("f3_pc_plus_4", bus.pc_plus_4, 32'h104);

        // Decode: plain instruction; ack ignored outside fetch
        @(negedge clk); #1;
        chk("dec_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("dec_ir_load", {31'd0, bus.ir_load}, 32'd0);
        chk("dec_exec_start", {31'd0, bus.exec_start}, 32'd0);
        bus.imem_ack = 1'b0;

        // Execute, done arrives on cycle 4 (== EXEC_TIMEOUT): done wins
        @(negedge clk); #1;
        chk("ex1_exec_start", {31'd0, bus.exec_start}, 32'd1);
        @(negedge clk); #1;
        chk("ex2_exec_start", {31'd0, bus.exec_start}, 32'd0);
        @(negedge clk); #1;
        @(negedge clk); bus.exec_done = 1'b1; #1;
        chk("ex4_fault", {31'd0, fault}, 32'd0);
        chk("ex4_exec_start", {31'd0, bus.exec_start}, 32'd0);

        // Update
        @(negedge clk); bus.exec_done = 1'b0; #1;
        chk("up1_pc_we", {31'd0, pc_we}, 32'd1);
        chk("up1_pc_before", pc, 32'h100);
        chk("up1_fault", {31'd0, fault}, 32'd0);
        @(negedge clk); #1;
        chk("up1_pc", pc, 32'h104);
        chk("up1_retired", retired, 32'd1);
        chk("up1_pc_we_off", {31'd0, pc_we}, 32'd0);
        chk("up1_imem_req", {31'd0, bus.imem_req}, 32'd1);

        // BZ branch, taken to 0x200
        bus.imem_ack = 1'b1;
        @(negedge clk); bus.imem_ack = 1'b0; bus.is_branch = 1'b1; bus.br_type = 2'b11; #1;
        chk("bz_dec_code", {29'd0, bus.branch_code}, 32'd0);
        @(negedge clk); bus.is_branch = 1'b0; bus.npc_in = 32'h200; #1;
        chk("bz_code", {29'd0, bus.branch_code}, 32'd4);
        chk("bz_pc_plus_4", bus.pc_plus_4, 32'h108);
        @(negedge clk); #1;
        chk("bz_code_after", {29'd0, bus.branch_code}, 32'd0);
        chk("bz_pc_we", {31'd0, pc_we}, 32'd1);
        @(negedge clk); #1;
        chk("bz_pc", pc, 32'h200);
        chk("bz_retired", retired, 32'd2);
        chk_stats("bz", 16'd1, 16'd1);

        // BR to pc + 4: executed but not taken
        bus.imem_ack = 1'b1;
        @(negedge clk); bus.imem_ack = 1'b0; bus.is_branch = 1'b1; bus.br_type = 2'b00; #1;
        @(negedge clk); bus.is_branch = 1'b0; bus.npc_in = 32'h204; #1;
        chk("br_code", {29'd0, bus.branch_code}, 32'd1);
        @(negedge clk); #1;
        chk("br_pc_we", {31'd0, pc_we}, 32'd1);
        @(negedge clk); #1;
        chk("br_pc", pc, 32'h204);
        chk("br_retired", retired, 32'd3);
        chk_stats("br", 16'd2, 16'd1);

        // BPL to misaligned 0x202: fault, halt, pc unchanged
        bus.imem_ack = 1'b1;
        @(negedge clk); bus.imem_ack = 1'b0; bus.is_branch = 1'b1; bus.br_type = 2'b10; #1;
        @(negedge clk); bus.is_branch = 1'b0; bus.npc_in = 32'h202; #1;
        chk("bpl_code", {29'd0, bus.branch_code}, 32'd3);
        @(negedge clk); #1;
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_halted", {31'd0, halted}, 32'd1);
        chk("mis_pc", pc, 32'h204);
        chk("mis_pc_we", {31'd0, pc_we}, 32'd0);
        chk("mis_retired", retired, 32'd3);
        chk_stats("mis", 16'd2, 16'd1);
        resume = 1'b1;
        @(negedge clk); resume = 1'b0; #1;
        chk("mis_resume_halted", {31'd0, halted}, 32'd1);
        chk("mis_resume_fault", {31'd0, fault}, 32'd1);
        chk("mis_resume_imem_req", {31'd0, bus.imem_req}, 32'd0);
        rst_n = 1'b0; #1;
        chk("mis_rst_fault", {31'd0, fault}, 32'd0);
        chk("mis_rst_halted", {31'd0, halted}, 32'd0);
        chk("mis_rst_pc", pc, 32'h100);
        chk("mis_rst_retired", retired, 32'd0);
        chk_stats("mis_rst", 16'd0, 16'd0);

        // Execute timeout: no exec_done for 4 cycles
        @(negedge clk); rst_n = 1'b1; bus.imem_ack = 1'b1; #1;
        chk("to_ir_load", {31'd0, bus.ir_load}, 32'd1);
        @(negedge clk); bus.imem_ack = 1'b0; #1;
        @(negedge clk); #1;
        chk("to_exec_start", {31'd0, bus.exec_start}, 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("to_c4_fault", {31'd0, fault}, 32'd0);
        chk("to_c4_halted", {31'd0, halted}, 32'd0);
        @(negedge clk); #1;
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_halted", {31'd0, halted}, 32'd1);
        chk("to_pc", pc, 32'h100);
        chk("to_retired", retired, 32'd0);
        rst_n = 1'b0; #1;
        chk("to_rst_fault", {31'd0, fault}, 32'd0);

        // HALT instruction (halt has priority over branch), then resume
        @(negedge clk); rst_n = 1'b1; bus.imem_ack = 1'b1; #1;
        @(negedge clk); bus.imem_ack = 1'b0; bus.is_halt = 1'b1; bus.is_branch = 1'b1; #1;
        @(negedge clk); bus.is_halt = 1'b0; bus.is_branch = 1'b0; #1;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_fault", {31'd0, fault}, 32'd0);
        chk("hlt_code", {29'd0, bus.branch_code}, 32'd0);
        chk("hlt_pc", pc, 32'h100);
        resume = 1'b1;
        @(negedge clk); resume = 1'b0; #1;
        chk("hlt_res_halted", {31'd0, halted}, 32'd0);
        chk("hlt_res_imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("hlt_res_pc", pc, 32'h100);
        chk("hlt_res_retired", retired, 32'd0);

        // One-cycle execute to move pc, then reset mid-fetch handshake
        bus.imem_ack = 1'b1;
        @(negedge clk); bus.imem_ack = 1'b0; #1;
        @(negedge clk); bus.exec_done = 1'b1; #1;
        chk("q_exec_start", {31'd0, bus.exec_start}, 32'd1);
        @(negedge clk); bus.exec_done = 1'b0; #1;
        chk("q_pc_we", {31'd0, pc_we}, 32'd1);
        @(negedge clk); bus.imem_ack = 1'b1; #1;
        chk("q_pc", pc, 32'h104);
        chk("q_retired", retired, 32'd1);
        chk("q_ir_load", {31'd0, bus.ir_load}, 32'd1);
        rst_n = 1'b0; #1;
        chk("mid_rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_rst_ir_load", {31'd0, bus.ir_load}, 32'd0);
        chk("mid_rst_pc", pc, 32'h100);
        chk("mid_rst_retired", retired, 32'd0);
        bus.imem_ack = 1'b0;

        @(negedge clk); rst_n = 1'b1; #1;
        chk("final_imem_req", {31'd0, bus.imem_req}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
